// File: rtl/fetch_queue.sv
// fetch_queue: {pc, instr} prefetch FIFO between fetch and decode.
// Optional macro FETCH_QUEUE_BYPASS_EN forwards input to output when empty.
module fetch_queue #(
    parameter int                DEPTH     = 4,
    parameter int                ADDR_W    = 2,
    parameter logic [31:0]       NOP_INSTR = 32'h00000013
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_pc,
    input  logic [31:0]       in_instr,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_pc,
    output logic [31:0]       out_instr,
    output logic [ADDR_W:0]   count
);

    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

    logic [63:0]       mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;

    logic not_empty;
    logic bypass;
    logic push;
    logic pop;
    logic [63:0] head;

    assign not_empty = (count_q != '0);
    assign in_ready  = (count_q != FULL_CNT);
    assign head      = mem_q[rd_ptr_q];

`ifdef FETCH_QUEUE_BYPASS_EN
    assign bypass = ~not_empty & in_valid & out_ready & ~flush;
`else
    assign bypass = 1'b0;
`endif

    assign push = in_valid & in_ready & ~flush & ~bypass;
    assign pop  = not_empty & out_ready & ~flush;

    // Head presentation: stored entry, forwarded input, or idle NOP.
    always_comb begin
        out_valid = not_empty;
        out_pc    = 32'h0;
        out_instr = NOP_INSTR;
        if (not_empty) begin
            out_pc    = head[63:32];
            out_instr = head[31:0];
        end else if (bypass) begin
            out_valid = 1'b1;
            out_pc    = in_pc;
            out_instr = in_instr;
        end
    end

    assign count = count_q;

    // Next-state for pointers and occupancy; flush empties the queue.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents need no reset since count guards reads.
    always_ff @(posedge clk) begin
        if (push & ~reset) begin
            mem_q[wr_ptr_q] <= {in_pc, in_instr};
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: randomized and directed checks of fetch_queue
// against a queue-based reference model.
module tb_fetch_queue;

    localparam int DEPTH = 4;
    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_instr;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic [2:0]  count;

    int n_checks = 0;
    int n_errors = 0;

    logic [63:0] mq[$];

    fetch_queue #(.DEPTH(4), .ADDR_W(2), .NOP_INSTR(NOP)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pc     (in_pc),
        .in_instr  (in_instr),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc    (out_pc),
        .out_instr (out_instr),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One cycle: drive, compare against model, clock, update model.
    task automatic step(input logic r, input logic iv,
                        input logic [31:0] pc, input logic [31:0] ins,
                        input logic fl, input logic ordy);
        logic        ev;
        logic [31:0] epc;
        logic [31:0] ein;
        logic        byp;
        logic        do_pop;
        logic        do_push;
        reset = r; in_valid = iv; in_pc = pc; in_instr = ins;
        flush = fl; out_ready = ordy;
        #1;
        byp = 1'b0;
`ifdef FETCH_QUEUE_BYPASS_EN
        byp = (mq.size() == 0) && iv && ordy && !fl;
`endif
        ev  = (mq.size() != 0);
        epc = ev ? mq[0][63:32] : 32'h0;
        ein = ev ? mq[0][31:0] : NOP;
        if (byp) begin
            ev = 1'b1; epc = pc; ein = ins;
        end
        check("out_valid", 64'(out_valid), 64'(ev));
        check("out_pc", 64'(out_pc), 64'(epc));
        check("out_instr", 64'(out_instr), 64'(ein));
        check("in_ready", 64'(in_ready), 64'(mq.size() != DEPTH));
        check("count", 64'(count), 64'(mq.size()));
        @(posedge clk);
        if (r || fl) begin
            mq.delete();
        end else if (!byp) begin
            do_pop  = (mq.size() != 0) && ordy;
            do_push = iv && (mq.size() < DEPTH);
            if (do_pop) void'(mq.pop_front());
            if (do_push) mq.push_back({pc, ins});
        end
        @(negedge clk);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_pc = '0; in_instr = '0;
        flush = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_count", 64'(count), 64'd0);
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_instr", 64'(out_instr), 64'(NOP));
        check("rst_pc", 64'(out_pc), 64'd0);
        check("rst_ready", 64'(in_ready), 64'd1);

        // Fill to full, overflow attempt, drain in order.
        for (int i = 0; i < 4; i++)
            step(1'b0, 1'b1, 32'(4 * i), 32'hA0 + 32'(i), 1'b0, 1'b0);
        check("fill_cnt", 64'(count), 64'd4);
        check("fill_rdy", 64'(in_ready), 64'd0);
        step(1'b0, 1'b1, 32'h10, 32'hA4, 1'b0, 1'b0);
        check("ovf_cnt", 64'(count), 64'd4);
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b0; out_ready = 1'b1; #1;
            check("drain_pc", 64'(out_pc), 64'(4 * i));
            step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        end
        check("drain_valid", 64'(out_valid), 64'd0);

        // Simultaneous push/pop at count 2 across pointer wrap.
        step(1'b0, 1'b1, 32'h200, 32'hB0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 32'h204, 32'hB1, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++)
            step(1'b0, 1'b1, 32'h208 + 32'(4 * i), 32'hB2 + 32'(i),
                 1'b0, 1'b1);
        check("pp_cnt", 64'(count), 64'd2);

        // Flush mid-stream with in_valid and out_ready asserted.
        step(1'b0, 1'b1, 32'h300, 32'hC0, 1'b0, 1'b0);
        check("pre_flush_cnt", 64'(count), 64'd3);
        step(1'b0, 1'b1, 32'h40, 32'hC1, 1'b1, 1'b1);
        check("flush_cnt", 64'(count), 64'd0);
        step(1'b0, 1'b1, 32'h100, 32'hC2, 1'b0, 1'b0);
        in_valid = 1'b0; #1;
        check("flush_head", 64'(out_pc), 64'h100);
        idle();

        // Reset together with flush and push at count 3.
        step(1'b0, 1'b1, 32'h400, 32'hD0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 32'h404, 32'hD1, 1'b0, 1'b0);
        check("pre_rst_cnt", 64'(count), 64'd3);
        step(1'b1, 1'b1, 32'h408, 32'hD2, 1'b1, 1'b1);
        idle();

        // Empty queue with input and out_ready: bypass or one-cycle latency.
        in_valid = 1'b1; in_pc = 32'h20; in_instr = 32'h00500093;
        out_ready = 1'b1; flush = 1'b0; #1;
`ifdef FETCH_QUEUE_BYPASS_EN
        check("byp_valid", 64'(out_valid), 64'd1);
        check("byp_pc", 64'(out_pc), 64'h20);
`else
        check("nobyp_valid", 64'(out_valid), 64'd0);
`endif
        step(1'b0, 1'b1, 32'h20, 32'h00500093, 1'b0, 1'b1);
        idle();

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            step(($urandom % 128) == 0, ($urandom % 4) != 0,
                 $urandom, $urandom, ($urandom % 32) == 0,
                 ($urandom % 3) != 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
